// File: rtl/removal_pass_scheduler_if.sv
// Cell-stream, flag-return and result signals between the decoder, the removal
// datapath and the pass scheduler.
interface removal_pass_scheduler_if #(
    parameter int unsigned RESULT_WIDTH = 16,
    parameter int unsigned PASS_WIDTH   = 8
);
    logic                    in_cell_valid;
    logic                    in_cell_last;
    logic                    in_cell_rop;
    logic                    in_end;
    logic                    pass_start;
    logic                    out_cell_valid;
    logic                    out_cell_last;
    logic                    out_cell_rop;
    logic                    rm_valid;
    logic                    rm_flag;
    logic [RESULT_WIDTH-1:0] total;
    logic                    total_valid;
    logic [PASS_WIDTH-1:0]   pass_count;
    logic                    error;

    modport master (
        output in_cell_valid, in_cell_last, in_cell_rop, in_end, rm_valid, rm_flag,
        input  pass_start, out_cell_valid, out_cell_last, out_cell_rop,
               total, total_valid, pass_count, error
    );

    modport slave (
        input  in_cell_valid, in_cell_last, in_cell_rop, in_end, rm_valid, rm_flag,
        output pass_start, out_cell_valid, out_cell_last, out_cell_rop,
               total, total_valid, pass_count, error
    );
endinterface

// File: rtl/removal_pass_scheduler.sv
// Stores the decoded roll grid and replays it through the removal datapath pass
// after pass, clearing flagged cells, until a pass removes nothing.
module removal_pass_scheduler #(
    parameter int unsigned MAX_COLS     = 160,
    parameter int unsigned MAX_ROWS     = 160,
    parameter int unsigned RESULT_WIDTH = 16,
    parameter int unsigned PASS_WIDTH   = 8
) (
    input logic                     clk,
    input logic                     test_logic_reset,
    removal_pass_scheduler_if.slave io_bus
);
    localparam int unsigned ColW = $clog2(MAX_COLS + 1);
    localparam int unsigned RowW = $clog2(MAX_ROWS + 1);
    localparam logic [ColW-1:0] ColLimit = ColW'(MAX_COLS);
    localparam logic [RowW-1:0] RowLimit = RowW'(MAX_ROWS);

    typedef enum logic [2:0] {
        StLoad,
        StStart,
        StReplay,
        StDrain,
        StCheck,
        StDone
    } state_e;

    state_e                  r_state;
    logic [ColW-1:0]         r_col;
    logic [ColW-1:0]         r_ncols;
    logic                    r_have_ncols;
    logic [RowW-1:0]         r_nrows;  // load row pointer, then the row count
    logic [RowW-1:0]         r_rd_row;
    logic [ColW-1:0]         r_rd_col;
    logic [RowW-1:0]         r_ret_row;
    logic [ColW-1:0]         r_ret_col;
    logic [RESULT_WIDTH-1:0] r_pass_removed;
    logic [RESULT_WIDTH-1:0] r_total;
    logic [PASS_WIDTH-1:0]   r_pass_count;
    logic                    r_pass_start;
    logic                    r_out_cell_valid;
    logic                    r_out_cell_last;
    logic                    r_out_cell_rop;
    logic                    r_total_valid;
    logic                    r_error;
    logic [MAX_COLS-1:0]     r_mem [MAX_ROWS];

    logic                    w_load_ok;
    logic [ColW-1:0]         w_row_len;
    logic                    w_rd_bit;
    logic                    w_rd_last_col;
    logic                    w_rd_last_row;
    logic                    w_ret_active;
    logic                    w_ret_bit;
    logic                    w_ret_last_col;
    logic [RESULT_WIDTH:0]   w_sum;
    logic [RESULT_WIDTH-1:0] w_total_next;
    logic [PASS_WIDTH-1:0]   w_pass_next;
    logic                    w_mem_we;
    logic [RowW-1:0]         w_mem_row;
    logic [ColW-1:0]         w_mem_col;
    logic                    w_mem_wdata;

    assign w_load_ok = (r_nrows < RowLimit) && (r_col < ColLimit);
    // A row whose tail was dropped still counts as MAX_COLS wide.
    assign w_row_len = (r_col < ColLimit) ? r_col + ColW'(1) : ColLimit;

    assign w_rd_bit      = r_mem[r_rd_row][r_rd_col];
    assign w_rd_last_col = (r_rd_col == r_ncols - ColW'(1));
    assign w_rd_last_row = (r_rd_row == r_nrows - RowW'(1));

    assign w_ret_active   = ((r_state == StReplay) || (r_state == StDrain)) &&
                            io_bus.rm_valid && (r_ret_row < r_nrows);
    assign w_ret_bit      = r_mem[r_ret_row][r_ret_col];
    assign w_ret_last_col = (r_ret_col == r_ncols - ColW'(1));

    assign w_sum        = {1'b0, r_total} + {1'b0, r_pass_removed};
    assign w_total_next = w_sum[RESULT_WIDTH] ? '1 : w_sum[RESULT_WIDTH-1:0];
    assign w_pass_next  = r_pass_count + PASS_WIDTH'(1);

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_row   = r_nrows;
        w_mem_col   = r_col;
        w_mem_wdata = io_bus.in_cell_rop;
        if (!test_logic_reset) begin
            if ((r_state == StLoad) && io_bus.in_cell_valid && !io_bus.in_end && w_load_ok) begin
                w_mem_we = 1'b1;
            end else if (w_ret_active && io_bus.rm_flag && w_ret_bit) begin
                w_mem_we    = 1'b1;
                w_mem_row   = r_ret_row;
                w_mem_col   = r_ret_col;
                w_mem_wdata = 1'b0;
            end
        end
    end

    // Replay reads are registered on the same edge, so they see the pre-write bit.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_row][w_mem_col] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (test_logic_reset) begin
            r_state          <= StLoad;
            r_col            <= '0;
            r_ncols          <= '0;
            r_have_ncols     <= 1'b0;
            r_nrows          <= '0;
            r_rd_row         <= '0;
            r_rd_col         <= '0;
            r_ret_row        <= '0;
            r_ret_col        <= '0;
            r_pass_removed   <= '0;
            r_total          <= '0;
            r_pass_count     <= '0;
            r_pass_start     <= 1'b0;
            r_out_cell_valid <= 1'b0;
            r_out_cell_last  <= 1'b0;
            r_out_cell_rop   <= 1'b0;
            r_total_valid    <= 1'b0;
            r_error          <= 1'b0;
        end else begin
            r_pass_start     <= 1'b0;
            r_out_cell_valid <= 1'b0;
            r_out_cell_last  <= 1'b0;
            r_out_cell_rop   <= 1'b0;

            if (w_ret_active) begin
                if (w_ret_last_col) begin
                    r_ret_col <= '0;
                    r_ret_row <= r_ret_row + RowW'(1);
                end else begin
                    r_ret_col <= r_ret_col + ColW'(1);
                end
                if (io_bus.rm_flag) begin
                    if (w_ret_bit) begin
                        if (r_pass_removed != '1) begin
                            r_pass_removed <= r_pass_removed + RESULT_WIDTH'(1);
                        end
                    end else begin
                        r_error <= 1'b1;
                    end
                end
            end

            unique case (r_state)
                StLoad: begin
                    if (io_bus.in_end) begin
                        if (r_nrows == '0) begin
                            r_state       <= StDone;
                            r_total_valid <= 1'b1;
                        end else begin
                            r_state      <= StStart;
                            r_pass_start <= 1'b1;
                        end
                    end else if (io_bus.in_cell_valid) begin
                        if (!w_load_ok) begin
                            r_error <= 1'b1;
                        end
                        if (io_bus.in_cell_last) begin
                            if (r_nrows < RowLimit) begin
                                if (!r_have_ncols) begin
                                    r_ncols      <= w_row_len;
                                    r_have_ncols <= 1'b1;
                                end else if (w_row_len != r_ncols) begin
                                    r_error <= 1'b1;
                                end
                                r_nrows <= r_nrows + RowW'(1);
                            end
                            r_col <= '0;
                        end else if (r_col < ColLimit) begin
                            r_col <= r_col + ColW'(1);
                        end
                    end
                end

                StStart: begin
                    r_rd_row       <= '0;
                    r_rd_col       <= '0;
                    r_ret_row      <= '0;
                    r_ret_col      <= '0;
                    r_pass_removed <= '0;
                    r_state        <= StReplay;
                end

                StReplay: begin
                    r_out_cell_valid <= 1'b1;
                    r_out_cell_rop   <= w_rd_bit;
                    r_out_cell_last  <= w_rd_last_col;
                    if (w_rd_last_col) begin
                        r_rd_col <= '0;
                        r_rd_row <= r_rd_row + RowW'(1);
                        if (w_rd_last_row) begin
                            r_state <= StDrain;
                        end
                    end else begin
                        r_rd_col <= r_rd_col + ColW'(1);
                    end
                end

                StDrain: begin
                    if (r_ret_row == r_nrows) begin
                        r_state <= StCheck;
                    end
                end

                StCheck: begin
                    r_total      <= w_total_next;
                    r_pass_count <= w_pass_next;
                    if (w_pass_next == '0) begin
                        r_error       <= 1'b1;
                        r_state       <= StDone;
                        r_total_valid <= 1'b1;
                    end else if (r_pass_removed == '0) begin
                        r_state       <= StDone;
                        r_total_valid <= 1'b1;
                    end else begin
                        r_state      <= StStart;
                        r_pass_start <= 1'b1;
                    end
                end

                StDone: begin
                    r_total_valid <= 1'b1;
                end

                default: begin
                    r_state <= StLoad;
                end
            endcase
        end
    end

    assign io_bus.pass_start     = r_pass_start;
    assign io_bus.out_cell_valid = r_out_cell_valid;
    assign io_bus.out_cell_last  = r_out_cell_last;
    assign io_bus.out_cell_rop   = r_out_cell_rop;
    assign io_bus.total          = r_total;
    assign io_bus.total_valid    = r_total_valid;
    assign io_bus.pass_count     = r_pass_count;
    assign io_bus.error          = r_error;
endmodule

// File: doc/removal_pass_scheduler.md
Name: removal_pass_scheduler

Overview:
- Holds the decoded roll grid in an on-chip bit store and replays it, one cell per cycle, through the accessible-roll counting datapath (adjacent column counter, previous row stores, counter).
- Takes back the per-cell removable flag and clears each removed cell in the store. Accumulates the removed total.
- Repeats full passes until a pass removes zero rolls, then presents the grand total to the TAP encoder.
- Sits between input_decoder and the counting datapath, in the tck domain.

Parameters:
- MAX_COLS, 160: maximum grid width in cells.
- MAX_ROWS, 160: maximum grid height in rows.
- RESULT_WIDTH, 16: width of the removed-roll totals.
- PASS_WIDTH, 8: width of the pass counter.

Ports:
- clk  in  1  tck.
- test_logic_reset  in  1  synchronous, active-high reset.
- in_cell_valid  in  1  decoded cell strobe from input_decoder.
- in_cell_last  in  1  qualifies the last cell of a row.
- in_cell_rop  in  1  1 = roll present.
- in_end  in  1  single-cycle pulse: input complete. Arrives after the final in_cell_last.
- pass_start  out  1  single-cycle pulse before each pass. The datapath clears its row stores on it.
- out_cell_valid  out  1  replay strobe to the datapath.
- out_cell_last  out  1  last cell of a replayed row.
- out_cell_rop  out  1  stored cell value.
- rm_valid  in  1  datapath returns one flag per cell, in raster order.
- rm_flag  in  1  1 = this cell is removable this pass.
- total  out  RESULT_WIDTH  accumulated removed rolls.
- total_valid  out  1  high in DONE.
- pass_count  out  PASS_WIDTH  passes executed, including the final zero pass.
- error  out  1  sticky: grid overflow, ragged row, or pass counter wrap.

Behaviour:
- Reset: every output is 0; state is LOAD; row, column, cell and pass counters are 0. The bit store is not cleared; rows at or beyond the row count are never read.
- Reset mid-pass: abandons the pass at once, with no further out_cell_valid, and returns to LOAD.
- LOAD:
  - Each in_cell_valid writes in_cell_rop at (row, col) and increments col.
  - On in_cell_last: the first row latches ncols = col+1. Every later row must match ncols, otherwise error is set.
  - col returns to 0 and row increments.
  - col reaching MAX_COLS or row reaching MAX_ROWS sets error; the offending cells are dropped.
  - in_end goes to START. If nrows = 0, in_end goes straight to DONE with total 0.
- START (1 cycle): pass_start = 1. Clears pass_removed and the read/return pointers, then goes to REPLAY.
- REPLAY:
  - Emits exactly one cell per cycle in raster order, with no gaps.
  - out_cell_last is high on col = ncols-1.
  - After the last cell (nrows*ncols emitted), goes to DRAIN.
- Flag return (REPLAY or DRAIN):
  - Each rm_valid advances the return pointer (raster order).
  - If rm_flag is 1 and the stored bit is 1: clear the bit and increment pass_removed.
  - If rm_flag is 1 and the stored bit is 0: ignore the flag and set error.
- Read/write ordering:
  - The datapath returns the flag for row r only after consuming row r+1, so writes always target cells already read this pass. This gives pass semantics equal to removing all flagged cells at the end of the pass.
  - When a same-cycle read and write hit the same row word, read data takes the pre-write value.
- DRAIN:
  - Waits until the return pointer equals nrows*ncols, then goes to CHECK.
  - rm_valid outside REPLAY/DRAIN is ignored.
- CHECK (1 cycle):
  - total += pass_removed, saturating at all-ones.
  - pass_count increments. A wrap to 0 sets error and goes to DONE.
  - If pass_removed = 0, go to DONE; otherwise go to START.
- DONE:
  - total_valid = 1 and the outputs hold.
  - in_cell_valid is ignored; only reset leaves DONE.
- A single-row or single-column grid is legal. Edge handling belongs to the datapath.

Test Plan:
- 3x3 all rolls, using a reference datapath model -> pass removals 4, 4, 1, 0. total = 9, pass_count = 4, error = 0.
- 3x3 all empty -> one pass, total = 0, pass_count = 1, total_valid rises within 2 cycles after the last rm_valid.
- Ragged input (row 0 has 5 cells, row 1 has 4) -> error = 1 and remains set through DONE.
- 161-cell row -> error = 1; ncols never exceeds 160; no out-of-range write.
- Reset asserted mid-REPLAY in pass 2 -> out_cell_valid = 0 the next cycle, all outputs 0. Reload of the same 3x3 grid -> total = 9.
- rm_flag = 1 on an empty cell -> error = 1 and pass_removed is unchanged for that cell.
